// File: rtl/alu_pkg.sv
// Shared types and ALU evaluation for the two-requester ALU share arbiter.
// Optional build macro: ALU_ARB_ILLEGAL_OP_EN (adds rsp_err on the top).
package alu_pkg;

    localparam int unsigned ALU_W = 32;
    localparam int unsigned NREQ  = 2;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_RSVD = 3'b011,
        ALU_ANDN = 3'b100,
        ALU_ORN  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_SLT  = 3'b111
    } alu_ctrl_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Combinational 32-bit ALU; reserved code yields zero.
    function automatic logic [ALU_W-1:0] alu_eval(input alu_ctrl_t con,
                                                  input logic [ALU_W-1:0] a,
                                                  input logic [ALU_W-1:0] b);
        logic [ALU_W-1:0] r;
        r = '0;
        case (con)
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_ADD:  r = ALU_W'(a + b);
            ALU_ANDN: r = a & ~b;
            ALU_ORN:  r = a | ~b;
            ALU_SUB:  r = ALU_W'(a - b);
            ALU_SLT:  r = ALU_W'($signed(a) < $signed(b));
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the requester at ptr wins when valid, else the other.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant,
    output logic       gid
);

    always_comb begin
        gid   = valid[ptr] ? ptr : ~ptr;
        grant = 2'b00;
        if (en && valid[gid]) begin
            grant[gid] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with a single registered result slot.
// Optional build macro: ALU_ARB_ILLEGAL_OP_EN adds rsp_err flagging accepted code 011.
module alu_share_arbiter
    import alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [2*ALU_W-1:0]     req_op1,
    input  logic [2*ALU_W-1:0]     req_op2,
    input  logic [5:0]             req_con,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [ALU_W-1:0]       rsp_res,
`ifdef ALU_ARB_ILLEGAL_OP_EN
    output logic                   rsp_err,
`endif
    output logic                   rsp_zf
);

    slot_state_t      state_q, state_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [ALU_W-1:0] res_q, res_d;
    logic             zf_q, zf_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic             err_q, err_d;

    logic             drain;
    logic             can_accept;
    logic [1:0]       grant;
    logic             gid;
    logic             accept;
    logic [ALU_W-1:0] op1_sel, op2_sel;
    alu_ctrl_t        con_sel;
    logic [ALU_W-1:0] alu_res;

    assign drain      = (state_q == SLOT_FULL) && rsp_ready[owner_q];
    assign can_accept = !reset && ((state_q == SLOT_EMPTY) || drain);

    rr_arb2 u_arb (
        .valid (req_valid),
        .ptr   (ptr_q),
        .en    (can_accept),
        .grant (grant),
        .gid   (gid)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // Operand mux in front of the single shared ALU.
    assign op1_sel = gid ? req_op1[2*ALU_W-1:ALU_W] : req_op1[ALU_W-1:0];
    assign op2_sel = gid ? req_op2[2*ALU_W-1:ALU_W] : req_op2[ALU_W-1:0];
    assign con_sel = alu_ctrl_t'(gid ? req_con[5:3] : req_con[2:0]);
    assign alu_res = alu_eval(con_sel, op1_sel, op2_sel);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        res_d       = res_q;
        zf_d        = zf_q;
        rsp_valid_d = rsp_valid_q;
        err_d       = err_q;
        if (accept) begin
            state_d     = SLOT_FULL;
            owner_d     = gid;
            ptr_d       = ~gid;
            res_d       = alu_res;
            zf_d        = (alu_res == '0);
            rsp_valid_d = gid ? 2'b10 : 2'b01;
            err_d       = (con_sel == ALU_RSVD);
        end else if (drain) begin
            state_d     = SLOT_EMPTY;
            rsp_valid_d = 2'b00;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SLOT_EMPTY;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            res_q       <= '0;
            zf_q        <= 1'b0;
            rsp_valid_q <= 2'b00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            res_q       <= res_d;
            zf_q        <= zf_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = res_q;
    assign rsp_zf    = zf_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    assign rsp_err   = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a cycle-level reference model of the slot and arbiter.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [5:0]  req_con;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_res;
    logic        rsp_zf;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic        rsp_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_con   (req_con),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
`ifdef ALU_ARB_ILLEGAL_OP_EN
        .rsp_err   (rsp_err),
`endif
        .rsp_zf    (rsp_zf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain integer terms.
    function automatic logic [31:0] m_alu(input logic [2:0] con, input logic [31:0] a, input logic [31:0] b);
        longint s;
        case (con)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: begin s = longint'(a) + longint'(b); return s[31:0]; end
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: begin s = longint'(a) - longint'(b); return s[31:0]; end
            3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Model state: slot occupancy, owner, held result, priority pointer.
    bit          m_full  = 0;
    int          m_owner = 0;
    logic [31:0] m_res   = 0;
    bit          m_err   = 0;
    int          m_ptr   = 0;

    function automatic int m_winner();
        bit can;
        int w;
        if (reset) return -1;
        can = !m_full || rsp_ready[m_owner];
        if (!can) return -1;
        w = req_valid[m_ptr] ? m_ptr : 1 - m_ptr;
        return req_valid[w] ? w : -1;
    endfunction

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        forever begin
            int w;
            logic [1:0] exp_rdy, exp_vld;
            @(negedge clk);
            w = m_winner();
            exp_rdy = (w < 0) ? 2'b00 : 2'(1 << w);
            exp_vld = m_full ? 2'(1 << m_owner) : 2'b00;
            chk("model_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("model_rsp_valid", 32'(rsp_valid), 32'(exp_vld));
            if (m_full) begin
                chk("model_rsp_res", rsp_res, m_res);
                chk("model_rsp_zf", 32'(rsp_zf), 32'(m_res == 0));
`ifdef ALU_ARB_ILLEGAL_OP_EN
                chk("model_rsp_err", 32'(rsp_err), 32'(m_err));
`endif
            end
            @(posedge clk);
            w = m_winner();
            if (reset) begin
                m_full = 0; m_owner = 0; m_res = 0; m_ptr = 0; m_err = 0;
            end else if (w >= 0) begin
                m_full  = 1;
                m_owner = w;
                m_res   = m_alu(req_con[w*3 +: 3], req_op1[w*32 +: 32], req_op2[w*32 +: 32]);
                m_err   = (req_con[w*3 +: 3] == 3'b011);
                m_ptr   = 1 - w;
            end else if (m_full && rsp_ready[m_owner]) begin
                m_full = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] con, input logic [31:0] a, input logic [31:0] b);
        req_con[i*3 +: 3]  = con;
        req_op1[i*32 +: 32] = a;
        req_op2[i*32 +: 32] = b;
    endtask

    typedef struct {
        logic [2:0]  con;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3'b111, 32'hFFFF_FFFF, 32'd1,          32'd1};
        vecs[1] = '{3'b111, 32'd1,          32'hFFFF_FFFF, 32'd0};
        vecs[2] = '{3'b010, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000};
        vecs[3] = '{3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        vecs[4] = '{3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000};
        vecs[5] = '{3'b101, 32'h0000_0001, 32'hFFFF_FFF0, 32'h0000_000F};
        vecs[6] = '{3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF};
        vecs[7] = '{3'b010, 32'hFFFF_FFFF, 32'd1,          32'd0};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        req_op1 = '0; req_op2 = '0; req_con = '0;
        cyc(); cyc();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        chk("rst_rsp_zf", 32'(rsp_zf), 32'd0);
        req_valid = 2'b00;
        reset = 1'b0;
        cyc();

        // 1: single ADD
        set_req(0, 3'b010, 32'd5, 32'd3);
        req_valid = 2'b01; rsp_ready = 2'b01;
        #1 chk("t1_ready", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b00;
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_res", rsp_res, 32'd8);
        chk("t1_zf", 32'(rsp_zf), 32'd0);
        cyc();

        // 2: both valid after reset, back-to-back grants
        reset = 1'b1; cyc(); reset = 1'b0;
        set_req(0, 3'b110, 32'd7, 32'd7);
        set_req(1, 3'b001, 32'h0F, 32'hF0);
        req_valid = 2'b11; rsp_ready = 2'b11;
        #1 chk("t2_ready0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b10;
        chk("t2_valid0", 32'(rsp_valid), 32'h1);
        chk("t2_res0", rsp_res, 32'd0);
        chk("t2_zf0", 32'(rsp_zf), 32'd1);
        chk("t2_ready1", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 2'b00;
        chk("t2_valid1", 32'(rsp_valid), 32'h2);
        chk("t2_res1", rsp_res, 32'hFF);
        cyc();

        // 3: operation table through requester 0
        foreach (vecs[k]) begin
            set_req(0, vecs[k].con, vecs[k].a, vecs[k].b);
            req_valid = 2'b01;
            cyc();
            chk($sformatf("t3_res%0d", k), rsp_res, vecs[k].exp);
            chk($sformatf("t3_zf%0d", k), 32'(rsp_zf), 32'(vecs[k].exp == 0));
        end
        req_valid = 2'b00;
        cyc();

        // 4: blocked slot holds, then drain-and-accept in one cycle
        set_req(0, 3'b010, 32'd1, 32'd2);
        req_valid = 2'b01; rsp_ready = 2'b00;
        cyc();
        set_req(1, 3'b010, 32'd10, 32'd20);
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1 chk("t4_ready_blocked", 32'(req_ready), 32'h0);
            chk("t4_res_held", rsp_res, 32'd3);
            chk("t4_valid_held", 32'(rsp_valid), 32'h1);
            rsp_ready = 2'b10;
            #1 chk("t4_nonowner_ignored", 32'(req_ready), 32'h0);
            rsp_ready = 2'b00;
            cyc();
        end
        rsp_ready = 2'b01;
        #1 chk("t4_ready_drain", 32'(req_ready), 32'h2);
        cyc();
        req_valid = 2'b00; rsp_ready = 2'b00;
        chk("t4_valid1", 32'(rsp_valid), 32'h2);
        chk("t4_res1", rsp_res, 32'd30);

        // 5: reset with slot full and both valid
        set_req(0, 3'b001, 32'h1, 32'h2);
        set_req(1, 3'b001, 32'h4, 32'h8);
        req_valid = 2'b11; reset = 1'b1;
        #1 chk("t5_ready_in_reset", 32'(req_ready), 32'h0);
        cyc();
        chk("t5_valid", 32'(rsp_valid), 32'h0);
        chk("t5_ready", 32'(req_ready), 32'h0);
        chk("t5_res", rsp_res, 32'd0);
        reset = 1'b0; rsp_ready = 2'b11;
        #1 chk("t5_ready_after", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 2'b00;
        chk("t5_valid_after", 32'(rsp_valid), 32'h1);
        chk("t5_res_after", rsp_res, 32'h3);

        // 6: reserved code
        set_req(1, 3'b011, 32'h1234, 32'h5678);
        req_valid = 2'b10;
        cyc();
        req_valid = 2'b00;
        chk("t6_valid", 32'(rsp_valid), 32'h2);
        chk("t6_res", rsp_res, 32'd0);
        chk("t6_zf", 32'(rsp_zf), 32'd1);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("t6_err", 32'(rsp_err), 32'd1);
`endif
        cyc();
        chk("t6_drained", 32'(rsp_valid), 32'h0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        chk("t6_err_clr", 32'(rsp_err), 32'd0);
`endif
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
